config_bus_arbiter: RTL and testbench
=====================================

CONFIG_BUS_ARBITER -- requirements
Module: config_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, cycles allowed for a downstream ack or read response before abort (range 2..255).
REQ-002 Parameter: RD_BIT, 3, address bit that marks a read transaction (1 = read, 0 = write).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rN_address  input  4  requester N (N = 0,1) register address.
REQ-006 rN_data  input  4  requester N write data.
REQ-007 rN_valid  input  1  requester N request strobe; a low-to-high transition starts a request.
REQ-008 rN_ack  output  1  one-cycle pulse when requester N's transaction completes.
REQ-009 rN_data_out  output  4  read data for requester N; held until its next read completes.
REQ-010 rN_data_out_valid  output  1  one-cycle pulse with rN_ack on read completion.
REQ-011 rN_err  output  1  one-cycle pulse on timeout abort of requester N's transaction.
REQ-012 rN_busy  output  1  requester N has a pending or in-flight request.
REQ-013 m_address, m_data  output  4 each  downstream config bus address and write data to the clock handler.
REQ-014 m_valid  output  1  downstream request, held high until m_ack.
REQ-015 m_ack  input  1  downstream accept pulse.
REQ-016 m_data_out  input  4  downstream read data.
REQ-017 m_data_out_valid  input  1  downstream read-data strobe.

Function
REQ-018 Capture: rN_valid is registered; when rN_valid=1 and its previous sample=0 and rN_busy=0, rN_address/rN_data are latched and rN_busy is set after that edge.
REQ-019 A rising edge on rN_valid while rN_busy=1 is dropped with no side effect.
REQ-020 FSM states: IDLE, ISSUE, WAIT_RD.
REQ-021 IDLE: if any requester is pending and not yet granted, grant one and enter ISSUE on the next edge; m_valid=1, with m_address/m_data from that requester's latch.
REQ-022 Arbitration is round-robin: the requester not granted last wins a tie; after reset r0 wins a tie.
REQ-023 ISSUE: m_address/m_data/m_valid are stable; on m_ack=1 the FSM goes to IDLE when the address bit RD_BIT=0, or to WAIT_RD when it is 1; m_valid=0 after that edge.
REQ-024 Write completion: rN_ack pulses on the cycle after the m_ack edge, and rN_busy clears at the same time.
REQ-025 WAIT_RD: on m_data_out_valid=1, m_data_out is registered to rN_data_out; rN_data_out_valid and rN_ack pulse for one cycle; rN_busy clears; the FSM enters IDLE.
REQ-026 Latency: after a lone write, the rising edge of rN_valid is sampled at edge k, m_valid is high after edge k+1, and rN_ack is high after the edge on which m_ack is sampled.
REQ-027 Timeout: an 8-bit counter clears on entry to ISSUE and to WAIT_RD; if it reaches TIMEOUT-1 without the awaited strobe, then rN_err pulses, rN_busy clears, m_valid=0, and the FSM enters IDLE.
REQ-028 m_ack outside ISSUE and m_data_out_valid outside WAIT_RD are ignored.
REQ-029 If an awaited strobe and the timeout occur in the same cycle, the strobe wins: the transaction completes and no err pulse is issued.
REQ-030 If a requester completes and its rN_valid rises in the same cycle, the new request is captured (the set wins over the clear).
REQ-031 At most one of rN_ack and rN_err pulses per transaction, and only for the granted requester.

Reset
REQ-032 On rst=1 at a clock edge: the FSM enters IDLE; all outputs go to 0, including rN_data_out=0; latches, busy flags, counter and edge-detect registers clear; the round-robin pointer is set to favour r0.
REQ-033 Reset during ISSUE or WAIT_RD abandons the transaction and issues no ack or err pulse.

Structure
REQ-034 Package config_bus_pkg holds the state enum, the TIMEOUT default, the RD_BIT default and the 4-bit bus width constant.
REQ-035 Sub-module cfg_req_slot, instantiated once per requester, holds the edge detect, the address/data latch and the busy flag.

Verification
REQ-036 r0 writes addr=1, data=2: m_valid rises 2 cycles after the r0_valid edge; m_ack 3 cycles later -> r0_ack pulse next cycle, r0_busy=0.
REQ-037 r0 and r1 edges in the same cycle (write 1/F and write 1/1): r0 is granted first, then r1; a repeat of both afterwards grants r1 first.
REQ-038 r1 reads addr=9: m_ack, then m_data_out=1 with m_data_out_valid -> r1_data_out=1, r1_data_out_valid and r1_ack pulse together.
REQ-039 A write with m_ack never driven: r0_err pulses TIMEOUT cycles after m_valid rises; m_valid=0; no r0_ack.
REQ-040 A second r0_valid edge while r0_busy=1 is dropped; exactly one downstream transaction and one r0_ack occur.
REQ-041 rst pulsed 2 cycles mid-WAIT_RD: all outputs 0, the FSM is in IDLE, a later write by r0 completes normally.

Source files
------------

// File: rtl/config_bus_pkg.sv
// Shared types and defaults for the configuration bus arbiter.
package config_bus_pkg;

    // Width of the address and data fields on every port.
    localparam int BUS_W       = 4;

    // Default cycle budget for a downstream ack or read response.
    localparam int TIMEOUT_DEF = 16;

    // Default address bit that marks a read transaction.
    localparam int RD_BIT_DEF  = 3;

    // Arbiter states; the encoding is visible on the state_dbg port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

endpackage

// File: rtl/cfg_req_slot.sv
// One requester slot: rising-edge detect on valid, address/data latch, busy flag.
module cfg_req_slot
    import config_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] address,
    input  logic [BUS_W-1:0] data,
    input  logic             valid,
    input  logic             clr,
    output logic             busy,
    output logic [BUS_W-1:0] lat_address,
    output logic [BUS_W-1:0] lat_data
);

    logic valid_q;
    logic capture;

    // A new request is taken on a valid rising edge when the slot is free,
    // or is being freed on this very edge (the new request wins the clear).
    assign capture = valid && !valid_q && (!busy || clr);

    // Edge-detect register, request latch and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            busy        <= 1'b0;
            lat_address <= '0;
            lat_data    <= '0;
        end else begin
            valid_q <= valid;
            if (capture) begin
                busy        <= 1'b1;
                lat_address <= address;
                lat_data    <= data;
            end else if (clr) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/config_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single downstream config bus,
// with write/read completion, read-data return and timeout abort.
//
// Handshake: a requester raises rN_valid (rising edge = new request) and
// waits for a one-cycle rN_ack (success) or rN_err (timeout). Downstream,
// m_valid is held with stable m_address/m_data until m_ack is sampled high;
// reads then wait for an m_data_out_valid strobe carrying m_data_out.
module config_bus_arbiter
    import config_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RD_BIT  = RD_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] r0_address,
    input  logic [BUS_W-1:0] r0_data,
    input  logic             r0_valid,
    output logic             r0_ack,
    output logic [BUS_W-1:0] r0_data_out,
    output logic             r0_data_out_valid,
    output logic             r0_err,
    output logic             r0_busy,
    input  logic [BUS_W-1:0] r1_address,
    input  logic [BUS_W-1:0] r1_data,
    input  logic             r1_valid,
    output logic             r1_ack,
    output logic [BUS_W-1:0] r1_data_out,
    output logic             r1_data_out_valid,
    output logic             r1_err,
    output logic             r1_busy,
    output logic [BUS_W-1:0] m_address,
    output logic [BUS_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ack,
    input  logic [BUS_W-1:0] m_data_out,
    input  logic             m_data_out_valid,
    output logic [1:0]       state_dbg
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             grant, grant_nxt;
    logic             last_grant, last_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [1:0]       busy, clr, ack_nxt, err_nxt;
    logic             dov_nxt;
    logic [BUS_W-1:0] lat_addr0, lat_addr1, lat_data0, lat_data1;
    logic [BUS_W-1:0] cur_addr, cur_data;
    logic [1:0]       sel;

    cfg_req_slot u_slot0 (
        .clk(clk), .rst(rst), .address(r0_address), .data(r0_data),
        .valid(r0_valid), .clr(clr[0]), .busy(busy[0]),
        .lat_address(lat_addr0), .lat_data(lat_data0)
    );

    cfg_req_slot u_slot1 (
        .clk(clk), .rst(rst), .address(r1_address), .data(r1_data),
        .valid(r1_valid), .clr(clr[1]), .busy(busy[1]),
        .lat_address(lat_addr1), .lat_data(lat_data1)
    );

    assign r0_busy   = busy[0];
    assign r1_busy   = busy[1];
    assign cur_addr  = grant ? lat_addr1 : lat_addr0;
    assign cur_data  = grant ? lat_data1 : lat_data0;
    assign sel       = grant ? 2'b10 : 2'b01;
    assign m_valid   = (state == ST_ISSUE);
    assign m_address = m_valid ? cur_addr : '0;
    assign m_data    = m_valid ? cur_data : '0;
    assign state_dbg = state;

    // Next-state, grant selection, timeout and completion pulses.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_grant;
        cnt_nxt   = cnt + 8'd1;
        clr       = 2'b00;
        ack_nxt   = 2'b00;
        err_nxt   = 2'b00;
        dov_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (busy != 2'b00) begin
                    // On a tie the requester not granted last goes first.
                    grant_nxt = (busy == 2'b11) ? !last_grant : busy[1];
                    last_nxt  = grant_nxt;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ack) begin
                    if (cur_addr[RD_BIT]) begin
                        state_nxt = ST_WAIT_RD;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                        clr       = sel;
                        ack_nxt   = sel;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    clr       = sel;
                    err_nxt   = sel;
                end
            end
            ST_WAIT_RD: begin
                // A strobe arriving on the last budget cycle still completes.
                if (m_data_out_valid) begin
                    state_nxt = ST_IDLE;
                    clr       = sel;
                    ack_nxt   = sel;
                    dov_nxt   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    clr       = sel;
                    err_nxt   = sel;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Grant bookkeeping, timeout counter and registered requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant             <= 1'b0;
            last_grant        <= 1'b1;
            cnt               <= '0;
            r0_ack            <= 1'b0;
            r1_ack            <= 1'b0;
            r0_err            <= 1'b0;
            r1_err            <= 1'b0;
            r0_data_out_valid <= 1'b0;
            r1_data_out_valid <= 1'b0;
            r0_data_out       <= '0;
            r1_data_out       <= '0;
        end else begin
            grant             <= grant_nxt;
            last_grant        <= last_nxt;
            cnt               <= cnt_nxt;
            r0_ack            <= ack_nxt[0];
            r1_ack            <= ack_nxt[1];
            r0_err            <= err_nxt[0];
            r1_err            <= err_nxt[1];
            r0_data_out_valid <= dov_nxt && !grant;
            r1_data_out_valid <= dov_nxt && grant;
            if (dov_nxt && !grant) r0_data_out <= m_data_out;
            if (dov_nxt && grant)  r1_data_out <= m_data_out;
        end
    end

endmodule

// File: tb/tb_config_bus_arbiter.sv
// Directed bench for config_bus_arbiter: inputs driven and outputs checked
// on the falling clock edge, one step at a time.
module tb_config_bus_arbiter;
    import config_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] r0_address, r0_data, r1_address, r1_data;
    logic       r0_valid, r1_valid;
    logic       r0_ack, r0_data_out_valid, r0_err, r0_busy;
    logic       r1_ack, r1_data_out_valid, r1_err, r1_busy;
    logic [3:0] r0_data_out, r1_data_out;
    logic [3:0] m_address, m_data, m_data_out;
    logic       m_valid, m_ack, m_data_out_valid;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    config_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_address(r0_address), .r0_data(r0_data), .r0_valid(r0_valid),
        .r0_ack(r0_ack), .r0_data_out(r0_data_out),
        .r0_data_out_valid(r0_data_out_valid), .r0_err(r0_err), .r0_busy(r0_busy),
        .r1_address(r1_address), .r1_data(r1_data), .r1_valid(r1_valid),
        .r1_ack(r1_ack), .r1_data_out(r1_data_out),
        .r1_data_out_valid(r1_data_out_valid), .r1_err(r1_err), .r1_busy(r1_busy),
        .m_address(m_address), .m_data(m_data), .m_valid(m_valid),
        .m_ack(m_ack), .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid),
        .state_dbg(state_dbg)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        r0_address = '0; r0_data = '0; r0_valid = 1'b0;
        r1_address = '0; r1_data = '0; r1_valid = 1'b0;
        m_ack = 1'b0; m_data_out = '0; m_data_out_valid = 1'b0;

        // Reset state.
        step(2);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_r0_busy", r0_busy, 0);
        chk("rst_r1_busy", r1_busy, 0);
        chk("rst_r0_ack", r0_ack, 0);
        chk("rst_r0_err", r0_err, 0);
        chk("rst_r1_dout", r1_data_out, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        step(1);

        // Tie after reset: r0 first; r0 re-requests on its completion edge,
        // r1's edge while busy is dropped; r1 (pending) then wins the tie.
        r0_address = 4'h1; r0_data = 4'hF; r0_valid = 1'b1;
        r1_address = 4'h1; r1_data = 4'h1; r1_valid = 1'b1;
        step(1);
        chk("tie_r0_busy", r0_busy, 1);
        chk("tie_r1_busy", r1_busy, 1);
        chk("tie_m_valid_early", m_valid, 0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        step(1);
        chk("tie_first_valid", m_valid, 1);
        chk("tie_first_data", m_data, 4'hF);
        chk("tie_first_addr", m_address, 4'h1);
        m_ack = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
        step(1);
        m_ack = 1'b0;
        chk("tie_r0_ack", r0_ack, 1);
        chk("tie_r1_ack_quiet", r1_ack, 0);
        chk("setwins_r0_busy", r0_busy, 1);
        chk("tie_r1_still_busy", r1_busy, 1);
        chk("tie_m_valid_gap", m_valid, 0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        step(1);
        chk("rr_second_data", m_data, 4'h1);
        chk("rr_second_valid", m_valid, 1);
        m_ack = 1'b1;
        step(1);
        m_ack = 1'b0;
        chk("rr_r1_ack", r1_ack, 1);
        chk("rr_r1_busy", r1_busy, 0);
        chk("rr_r0_ack_quiet", r0_ack, 0);
        step(1);
        chk("rr_third_data", m_data, 4'hF);
        m_ack = 1'b1;
        step(1);
        m_ack = 1'b0;
        chk("rr_r0_ack2", r0_ack, 1);
        chk("rr_r0_busy2", r0_busy, 0);
        step(1);
        chk("rr_r0_ack_end", r0_ack, 0);

        // Lone write: addr 1, data 2.
        r0_address = 4'h1; r0_data = 4'h2; r0_valid = 1'b1;
        step(1);
        chk("wr_m_valid_k", m_valid, 0);
        chk("wr_busy", r0_busy, 1);
        step(1);
        chk("wr_m_valid_k1", m_valid, 1);
        chk("wr_m_addr", m_address, 4'h1);
        chk("wr_m_data", m_data, 4'h2);
        r0_valid = 1'b0;
        step(2);
        chk("wr_m_valid_hold", m_valid, 1);
        m_ack = 1'b1;
        step(1);
        m_ack = 1'b0;
        chk("wr_r0_ack", r0_ack, 1);
        chk("wr_r0_busy", r0_busy, 0);
        chk("wr_m_valid_low", m_valid, 0);
        chk("wr_no_dov", r0_data_out_valid, 0);
        step(1);
        chk("wr_ack_pulse", r0_ack, 0);

        // r1 read of address 9; stray m_ack during WAIT_RD is ignored.
        r1_address = 4'h9; r1_data = 4'h0; r1_valid = 1'b1;
        step(2);
        chk("rd_m_addr", m_address, 4'h9);
        m_ack = 1'b1;
        r1_valid = 1'b0;
        step(1);
        chk("rd_state_wait", state_dbg, ST_WAIT_RD);
        chk("rd_m_valid_low", m_valid, 0);
        chk("rd_no_ack_yet", r1_ack, 0);
        step(1);
        m_ack = 1'b0;
        chk("rd_stray_ack_ignored", state_dbg, ST_WAIT_RD);
        m_data_out = 4'h1; m_data_out_valid = 1'b1;
        step(1);
        m_data_out_valid = 1'b0; m_data_out = 4'h0;
        chk("rd_r1_dout", r1_data_out, 4'h1);
        chk("rd_r1_dov", r1_data_out_valid, 1);
        chk("rd_r1_ack", r1_ack, 1);
        chk("rd_r1_busy", r1_busy, 0);
        chk("rd_r0_dout", r0_data_out, 4'h0);
        step(1);
        chk("rd_dov_pulse", r1_data_out_valid, 0);
        chk("rd_dout_held", r1_data_out, 4'h1);

        // Write with no m_ack: err TIMEOUT cycles after m_valid rises.
        r0_address = 4'h3; r0_data = 4'h7; r0_valid = 1'b1;
        step(2);
        chk("to_m_valid", m_valid, 1);
        r0_valid = 1'b0;
        step(15);
        chk("to_err_early", r0_err, 0);
        chk("to_m_valid_late", m_valid, 1);
        step(1);
        chk("to_err", r0_err, 1);
        chk("to_m_valid_drop", m_valid, 0);
        chk("to_busy", r0_busy, 0);
        chk("to_no_ack", r0_ack, 0);
        step(1);
        chk("to_err_pulse", r0_err, 0);

        // Read whose data strobe lands on the last budget cycle: completes.
        r1_address = 4'h8; r1_valid = 1'b1;
        step(2);
        m_ack = 1'b1;
        r1_valid = 1'b0;
        step(1);
        m_ack = 1'b0;
        step(15);
        m_data_out = 4'hA; m_data_out_valid = 1'b1;
        step(1);
        m_data_out_valid = 1'b0;
        chk("race_r1_ack", r1_ack, 1);
        chk("race_r1_err", r1_err, 0);
        chk("race_r1_dout", r1_data_out, 4'hA);
        step(1);
        chk("race_r1_err_after", r1_err, 0);

        // Second r0 edge while busy is dropped: one transaction, one ack.
        r0_address = 4'h4; r0_data = 4'h6; r0_valid = 1'b1;
        step(1);
        r0_valid = 1'b0;
        step(1);
        chk("drop_m_data", m_data, 4'h6);
        r0_address = 4'h5; r0_data = 4'hC; r0_valid = 1'b1;
        step(1);
        r0_valid = 1'b0;
        chk("drop_m_data_stable", m_data, 4'h6);
        m_ack = 1'b1;
        step(1);
        m_ack = 1'b0;
        chk("drop_r0_ack", r0_ack, 1);
        chk("drop_r0_busy", r0_busy, 0);
        step(1);
        chk("drop_no_second_busy", r0_busy, 0);
        chk("drop_no_second_ack", r0_ack, 0);
        step(1);
        chk("drop_no_second_txn", m_valid, 0);

        // Reset for two cycles in the middle of WAIT_RD.
        r0_address = 4'hA; r0_data = 4'h0; r0_valid = 1'b1;
        step(2);
        m_ack = 1'b1;
        r0_valid = 1'b0;
        step(1);
        m_ack = 1'b0;
        chk("mid_rst_state_before", state_dbg, ST_WAIT_RD);
        apply_reset();
        chk("mid_rst_state", state_dbg, ST_IDLE);
        chk("mid_rst_busy", r0_busy, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_r1_dout", r1_data_out, 0);
        chk("mid_rst_r0_ack", r0_ack, 0);
        chk("mid_rst_r0_err", r0_err, 0);
        r0_address = 4'h2; r0_data = 4'h3; r0_valid = 1'b1;
        step(2);
        chk("post_rst_m_valid", m_valid, 1);
        chk("post_rst_m_data", m_data, 4'h3);
        m_ack = 1'b1;
        r0_valid = 1'b0;
        step(1);
        m_ack = 1'b0;
        chk("post_rst_ack", r0_ack, 1);
        chk("post_rst_err", r0_err, 0);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
